// File: rtl/dig_ota_bank_if.sv
// Pad-side bundle for dig_ota_bank: comparator inputs, filter controls and
// the filtered outputs, edge pulses and event count.
interface dig_ota_bank_if #(
  parameter int CHANNELS = 4,
  parameter int FILT_W   = 4
);
  logic                en;
  logic [CHANNELS-1:0] vip;
  logic [CHANNELS-1:0] vin;
  logic [FILT_W-1:0]   filt_len;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [7:0]          evt_cnt;

  // No handshake here: inputs are level signals sampled every clk edge, and
  // outputs are registered levels/pulses valid for the whole following cycle.
  modport master (
    output en, vip, vin, filt_len,
    input  out, rise, fall, evt_cnt
  );

  modport slave (
    input  en, vip, vin, filt_len,
    output out, rise, fall, evt_cnt
  );
endinterface

// File: rtl/dig_ota_bank.sv
// Multi-channel digital comparator front-end: synchroniser, consecutive-sample
// filter and edge pulses per channel. Macro DIGOTA_EVTCNT_EN enables evt_cnt.
module dig_ota_bank #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic           clk,
  input  logic           rst,
  dig_ota_bank_if.slave  bus
);
  localparam logic [FILT_W:0] ONE_W = (FILT_W+1)'(1);

  logic [CHANNELS-1:0] p_pipe [SYNC_STAGES];
  logic [CHANNELS-1:0] n_pipe [SYNC_STAGES];
  logic [CHANNELS-1:0] p_s, n_s;

  logic [FILT_W-1:0]   cnt     [CHANNELS];
  logic [FILT_W-1:0]   cnt_nxt [CHANNELS];
  logic [FILT_W:0]     cnt_inc;
  logic [FILT_W-1:0]   eff_len;
  logic [CHANNELS-1:0] out_r, out_nxt, rise_r, fall_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        p_pipe[s] <= '0;
        n_pipe[s] <= '0;
      end
    end else begin
      p_pipe[0] <= bus.vip;
      n_pipe[0] <= bus.vin;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        p_pipe[s] <= p_pipe[s-1];
        n_pipe[s] <= n_pipe[s-1];
      end
    end
  end

  assign p_s     = p_pipe[SYNC_STAGES-1];
  assign n_s     = n_pipe[SYNC_STAGES-1];
  assign eff_len = (bus.filt_len == '0) ? FILT_W'(1) : bus.filt_len;

  // A decision exists only when p_s != n_s, and then the wanted level is p_s.
  always_comb begin
    out_nxt = out_r;
    cnt_inc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = cnt[i];
      cnt_inc    = {1'b0, cnt[i]} + ONE_W;
      if (!bus.en) begin
        cnt_nxt[i] = '0;
      end else if (p_s[i] != n_s[i]) begin
        if (p_s[i] == out_r[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt_inc >= {1'b0, eff_len}) begin
          out_nxt[i] = p_s[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt_inc[FILT_W-1:0];
        end
      end
    end
  end

  // Pulses are registered alongside out so they coincide with the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r  <= '0;
      rise_r <= '0;
      fall_r <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      out_r  <= out_nxt;
      rise_r <= out_nxt & ~out_r;
      fall_r <= ~out_nxt & out_r;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign bus.out  = out_r;
  assign bus.rise = rise_r;
  assign bus.fall = fall_r;

`ifdef DIGOTA_EVTCNT_EN
  logic [7:0]          evt_r;
  logic [8:0]          evt_sum;
  logic [CHANNELS-1:0] evt_bits;

  assign evt_bits = rise_r | fall_r;

  always_comb begin
    evt_sum = {1'b0, evt_r};
    for (int i = 0; i < CHANNELS; i++) evt_sum = evt_sum + {8'b0, evt_bits[i]};
  end

  // Saturates at 255 rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) evt_r <= '0;
    else     evt_r <= evt_sum[8] ? 8'hFF : evt_sum[7:0];
  end

  assign bus.evt_cnt = evt_r;
`else
  assign bus.evt_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_dig_ota_bank.sv
// Directed bench for dig_ota_bank (CHANNELS=4, SYNC_STAGES=2, FILT_W=4) with
// hand-computed expectations; evt_cnt expectations follow DIGOTA_EVTCNT_EN.
module tb_dig_ota_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  dig_ota_bank_if #(.CHANNELS(4), .FILT_W(4)) bus ();

  dig_ota_bank #(.CHANNELS(4), .SYNC_STAGES(2), .FILT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] o, input logic [3:0] r,
                           input logic [3:0] f);
    check({tag, ".out"},  {28'b0, bus.out},  {28'b0, o});
    check({tag, ".rise"}, {28'b0, bus.rise}, {28'b0, r});
    check({tag, ".fall"}, {28'b0, bus.fall}, {28'b0, f});
  endtask

  task automatic check_evt(input string tag, input logic [7:0] exp_on);
`ifdef DIGOTA_EVTCNT_EN
    check(tag, {24'b0, bus.evt_cnt}, {24'b0, exp_on});
`else
    check(tag, {24'b0, bus.evt_cnt}, 32'h0);
`endif
  endtask

  initial begin
    bus.en       = 1'b1;
    bus.filt_len = 4'd3;
    bus.vip      = 4'hF;
    bus.vin      = 4'h0;

    // Reset held for three cycles dominates en and the inputs.
    step(1);
    for (int c = 0; c < 3; c++) begin
      step(1);
      check_all("reset", 4'h0, 4'h0, 4'h0);
      check_evt("reset.evt", 8'd0);
    end
    rst = 1'b0;
    step(4);
    check_all("rel.e4", 4'h0, 4'h0, 4'h0);
    step(1);
    check_all("rel.e5", 4'hF, 4'hF, 4'h0);
    step(1);
    check_all("rel.e6", 4'hF, 4'h0, 4'h0);
    check_evt("rel.evt", 8'd4);

    // filt_len=0 acts as 1: all channels fall three edges after the change.
    bus.filt_len = 4'd0;
    bus.vip      = 4'h0;
    bus.vin      = 4'hF;
    step(2);
    check_all("fl0.e2", 4'hF, 4'h0, 4'h0);
    step(1);
    check_all("fl0.e3", 4'h0, 4'h0, 4'hF);
    step(1);
    check_all("fl0.e4", 4'h0, 4'h0, 4'h0);

    // Glitch rejection on channel 0 with filt_len=4: runs of 3 never flip.
    bus.filt_len = 4'd4;
    bus.vip = 4'b0001; bus.vin = 4'b1110; step(3);
    bus.vip = 4'b0000; bus.vin = 4'b1111; step(1);
    bus.vip = 4'b0001; bus.vin = 4'b1110; step(3);
    bus.vip = 4'b0000; bus.vin = 4'b1111; step(1);
    bus.vip = 4'b0001; bus.vin = 4'b1110;
    step(2);
    check_all("glitch.hold", 4'h0, 4'h0, 4'h0);
    step(3);
    check_all("glitch.e5", 4'h0, 4'h0, 4'h0);
    step(1);
    check_all("glitch.e6", 4'b0001, 4'b0001, 4'h0);

    // Channel 1: two disagreeing samples, twenty equal ones, then two more.
    bus.vip = 4'b0011; bus.vin = 4'b1100; step(2);
    bus.vip = 4'b0011; bus.vin = 4'b1110;
    for (int c = 0; c < 20; c++) begin
      step(1);
      check_all("equal", 4'b0001, 4'h0, 4'h0);
    end
    bus.vip = 4'b0011; bus.vin = 4'b1100;
    step(3);
    check_all("equal.e3", 4'b0001, 4'h0, 4'h0);
    step(1);
    check_all("equal.e4", 4'b0011, 4'b0010, 4'h0);

    // Channel 2 with filt_len=0: rise then fall, each three edges after change.
    bus.filt_len = 4'd0;
    bus.vip = 4'b0111; bus.vin = 4'b1000;
    step(2);
    check_all("ch2up.e2", 4'b0011, 4'h0, 4'h0);
    step(1);
    check_all("ch2up.e3", 4'b0111, 4'b0100, 4'h0);
    bus.vip = 4'b0011; bus.vin = 4'b1100;
    step(2);
    check_all("ch2dn.e2", 4'b0111, 4'h0, 4'h0);
    step(1);
    check_all("ch2dn.e3", 4'b0011, 4'h0, 4'b0100);

    // Enable gating on channel 3 (filt_len=3): two samples counted, then en=0.
    bus.filt_len = 4'd3;
    bus.vip = 4'b1011; bus.vin = 4'b0100;
    step(4);
    bus.en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      check_all("en_off", 4'b0011, 4'h0, 4'h0);
    end
    bus.en = 1'b1;
    step(2);
    check_all("en_on.e2", 4'b0011, 4'h0, 4'h0);
    step(1);
    check_all("en_on.e3", 4'b1011, 4'b1000, 4'h0);
    step(1);
    check_all("en_on.e4", 4'b1011, 4'h0, 4'h0);
    check_evt("evt.13", 8'd13);

    // Toggle every channel each cycle until evt_cnt saturates, then settle low.
    bus.filt_len = 4'd0;
    for (int k = 0; k < 75; k++) begin
      bus.vip = (k % 2 == 0) ? 4'h0 : 4'hF;
      bus.vin = ~bus.vip;
      step(1);
    end
    step(5);
    check_all("toggle.end", 4'h0, 4'h0, 4'h0);
    check_evt("evt.sat", 8'd255);

    // Reset dominates en mid-run.
    rst     = 1'b1;
    bus.vip = 4'hF;
    bus.vin = 4'h0;
    step(1);
    check_all("rst2", 4'h0, 4'h0, 4'h0);
    check_evt("rst2.evt", 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
